// File: rtl/i2s_dac_tx.sv
// Purpose : I2S (Philips) serializer for the WM8731 DAC; bit-clock/LR-clock master, one stereo pair per frame.
// Latency : a pair accepted into holding is sent in the next frame; dacdat lags the slot edge by one BCLK.
// Backpres: sample_ready is low while a pair is held; the holding register drains at each left-slot start.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   enable       codec configuration finished; low forces the serializer idle (holding is kept)
//   sample_left  left-channel PCM sample, two's complement
//   sample_right right-channel PCM sample, two's complement
//   sample_valid sample_left/right hold a valid pair
//   sample_ready holding register can accept a pair (combinational: enable & ~holding_full)
//   bclk         I2S bit clock, period 2*BCLK_DIV clk
//   lrclk        DACLRC: 0 = left slot, 1 = right slot
//   dacdat       serial data, updated only in the clk where bclk falls
//   frame_start  one-clk pulse when a left slot begins
//   underrun     one-clk pulse when a frame begins with no pair held
module i2s_dac_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 32,
  parameter int BCLK_DIV     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    dacdat,
  output logic                    frame_start,
  output logic                    underrun
);

  // A one-cycle divider still needs a 1-bit counter so the compare below stays legal.
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(SLOT_BITS);

  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt;
  logic                    chan;          // 1 = right slot
  logic                    running;       // a falling event has happened since idle
  logic [SAMPLE_WIDTH-1:0] holding_l;
  logic [SAMPLE_WIDTH-1:0] holding_r;
  logic                    holding_full;
  logic [SAMPLE_WIDTH-1:0] shift_l;
  logic [SAMPLE_WIDTH-1:0] shift_r;

  logic          div_tc;
  logic          fall_evt;
  logic          slot_wrap;
  logic [BW-1:0] bit_nxt;
  logic          chan_nxt;
  logic          left_start;
  logic          dat_active;
  logic          dat_nxt;
  logic          xfer;

  assign sample_ready = enable & ~holding_full;
  assign xfer         = sample_valid & sample_ready;

  assign div_tc   = (div_cnt == DW'(BCLK_DIV - 1));
  // bclk is high and about to toggle: this clk is a falling event.
  assign fall_evt = enable & div_tc & bclk;

  // Idle parks the counters at bit 0 of the right slot, so the very first
  // falling event after enable is treated as a slot wrap into the left slot.
  assign slot_wrap  = ~running | (bit_cnt == BW'(SLOT_BITS - 1));
  assign bit_nxt    = slot_wrap ? '0 : bit_cnt + BW'(1);
  assign chan_nxt   = slot_wrap ? ~chan : chan;
  assign left_start = fall_evt & slot_wrap & chan;

  // Bits 1..SAMPLE_WIDTH of a slot carry the sample; bit 0 is the I2S delay bit.
  assign dat_active = (bit_nxt != '0) && (bit_nxt <= BW'(SAMPLE_WIDTH));
  assign dat_nxt    = dat_active ? (chan_nxt ? shift_r[SAMPLE_WIDTH-1]
                                             : shift_l[SAMPLE_WIDTH-1])
                                 : 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      chan         <= 1'b1;
      running      <= 1'b0;
      bclk         <= 1'b0;
      lrclk        <= 1'b1;
      dacdat       <= 1'b0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
      holding_l    <= '0;
      holding_r    <= '0;
      holding_full <= 1'b0;
      shift_l      <= '0;
      shift_r      <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      if (!enable) begin
        // Abandon the partial frame; the held pair survives for the restart.
        div_cnt <= '0;
        bit_cnt <= '0;
        chan    <= 1'b1;
        running <= 1'b0;
        bclk    <= 1'b0;
        lrclk   <= 1'b1;
        dacdat  <= 1'b0;
      end else begin
        if (div_tc) begin
          div_cnt <= '0;
          bclk    <= ~bclk;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end

        if (fall_evt) begin
          running <= 1'b1;
          bit_cnt <= bit_nxt;
          chan    <= chan_nxt;
          dacdat  <= dat_nxt;
          if (slot_wrap) begin
            lrclk <= chan_nxt;
          end

          if (left_start) begin
            frame_start <= 1'b1;
            if (holding_full) begin
              shift_l      <= holding_l;
              shift_r      <= holding_r;
              holding_full <= 1'b0;
            end else begin
              shift_l  <= '0;
              shift_r  <= '0;
              underrun <= 1'b1;
            end
          end else if (dat_active) begin
            if (chan_nxt) begin
              shift_r <= {shift_r[SAMPLE_WIDTH-2:0], 1'b0};
            end else begin
              shift_l <= {shift_l[SAMPLE_WIDTH-2:0], 1'b0};
            end
          end
        end
      end

      // Placed last: a pair arriving on the same clk as an underrunning
      // left-slot start is kept for the following frame.
      if (xfer) begin
        holding_l    <= sample_left;
        holding_r    <= sample_right;
        holding_full <= 1'b1;
      end
    end
  end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Audio sample serializer for the WM8731 DAC path, placed directly downstream of the codec configuration FSM.
- It is gated by that FSM's "configuration finished" condition and then streams stereo PCM to the codec in I2S (Philips) format.
- The block is the bit-clock and LR-clock master. It accepts one stereo sample pair per frame through a valid/ready handshake from the synth voice/mixer logic.

Parameters:
- SAMPLE_WIDTH, 16: bits per channel sample, two's complement, sent MSB first.
- SLOT_BITS, 32: BCLK periods per channel slot. Must be ≥ SAMPLE_WIDTH+1.
- BCLK_DIV, 4: clk cycles per BCLK half-period. Must be ≥ 1. BCLK period = 2*BCLK_DIV clk.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  high once codec configuration has finished; low holds the serializer idle.
- sample_left  input  SAMPLE_WIDTH  left-channel sample.
- sample_right  input  SAMPLE_WIDTH  right-channel sample.
- sample_valid  input  1  sample_left/right hold a valid pair.
- sample_ready  output  1  holding register can accept a pair.
- bclk  output  1  I2S bit clock to the codec.
- lrclk  output  1  DACLRC to the codec; 0 = left slot, 1 = right slot.
- dacdat  output  1  serial data; changes only on BCLK falling edges.
- frame_start  output  1  one-clk pulse when a new left slot begins.
- underrun  output  1  one-clk pulse when a frame starts with no sample pair available.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: bclk=0, lrclk=1, dacdat=0, frame_start=0, underrun=0.
  - Internal state: divider counter=0, bit counter=0, channel=right, holding register empty, shift registers=0.
- Ready rule: sample_ready = enable & ~holding_full (combinational). A transfer occurs when sample_valid & sample_ready at a clk edge; the pair is latched into holding and holding_full is set.
- Divider:
  - While enable=1, div_cnt counts 0..BCLK_DIV-1.
  - At terminal count, div_cnt wraps to 0 and bclk toggles.
  - A 0→1 toggle is a rising event; a 1→0 toggle is a falling event. All serializer updates happen only on falling events, in the same clk that bclk goes low.
- Bit counter b runs 0..SLOT_BITS-1 per slot and advances on each falling event. On wrap, the channel flips.
- Start of left slot (falling event with b wrapping to 0 and channel becoming left):
  - lrclk <= 0 and frame_start pulses.
  - If holding_full: shift_l/shift_r load from holding and holding_full clears.
  - Otherwise: shift_l/shift_r load 0 and underrun pulses.
- Start of right slot: lrclk <= 1. No load occurs.
- dacdat per slot:
  - b=0: 0.
  - b=1..SAMPLE_WIDTH: channel sample, MSB first (one-BCLK I2S delay).
  - b>SAMPLE_WIDTH: 0.
- First frame after enable rises from idle:
  - First rising event at BCLK_DIV clks.
  - First falling event at 2*BCLK_DIV clks; this is the start of the left slot (lrclk 1→0).
- Frame length: 2*SLOT_BITS*2*BCLK_DIV clk. With defaults this is 512 clk, i.e. 48.8 kHz at 25 MHz clk.
- enable falls at any point:
  - Next clk: synchronous return to the idle state (bclk=0, lrclk=1, dacdat=0, counters=0, channel=right).
  - The holding register and its full flag are retained.
  - The partial frame is abandoned.
- Simultaneous events:
  - Transfer and left-slot load in the same clk with holding empty: the frame underruns and loads 0. The incoming pair goes to holding for the next frame.
  - Transfer and left-slot load in the same clk with holding full: not possible, because sample_ready=0.
- Reset mid-frame: immediate idle. The holding pair is discarded.
- Outputs bclk, lrclk, dacdat, frame_start and underrun are registered; no combinational path from inputs to them.

Test Plan:
- Reset with enable=1: hold reset=0 for 5 clk → bclk=0, lrclk=1, dacdat=0, sample_ready=1 throughout. Release → first bclk rise at clk 4 and first fall at clk 8 with lrclk=0, frame_start pulse.
- Single pair L=16'hA5F0, R=16'h0F0F preloaded → dacdat sampled on each bclk rise in the left slot is 0,1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0 followed by 15 zeros; right slot is 0,0000111100001111, then 15 zeros.
- No sample offered → underrun pulses once per frame (every 512 clk), and dacdat stays 0 for the whole frame.
- Back-pressure: offer pairs continuously with sample_valid=1 → exactly one accept per frame. sample_ready drops for the clk after each accept and stays low until the next frame_start. Accepted values appear in order.
- Drop enable at clk 200 of a frame → next clk bclk=0, lrclk=1, counters idle. Re-raise enable → the frame restarts with the retained holding pair at the first falling event, and no underrun.
- Assert reset mid-right-slot → outputs take reset values asynchronously within the same clk. The pending holding pair is gone, and the next frame underruns.
